// File: rtl/edit_mode_sel.sv
// ============================================================================
// edit_mode_sel : button-driven field selector / edit strobe generator
// Optional auto-repeat on held add/deduct: define EDIT_AUTOREPEAT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module edit_mode_sel #(
   parameter int NUM_FIELDS    = 3,
   parameter int TIMEOUT_CYC   = 50_000_000,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              switch,
   input  logic                              add,
   input  logic                              deduct,
   output logic                              mode,
   output logic [$clog2(NUM_FIELDS+1)-1:0]   field,
   output logic [2*NUM_FIELDS-1:0]           operator
);

   localparam int c_fw = $clog2(NUM_FIELDS + 1);
   localparam int c_iw = $clog2(TIMEOUT_CYC + 2);
   localparam logic [c_iw-1:0] c_idle_last = c_iw'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
   localparam logic [c_fw-1:0] c_field_max = c_fw'(NUM_FIELDS);

   // bit 0 = switch, bit 1 = add, bit 2 = deduct
   logic [2:0] w_pins;
   logic [2:0] r_sync1;
   logic [2:0] r_sync2;
   logic [2:0] r_prev;
   logic [1:0] r_flush;
   logic [2:0] w_press;

   assign w_pins = {deduct, add, switch};

   // r_prev is held at 0 until the synchronizers carry real pin values, so a
   // button already held low at reset release never looks like a fresh press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 3'b111;
         r_sync2 <= 3'b111;
         r_prev  <= 3'b000;
         r_flush <= 2'd0;
      end else begin
         r_sync1 <= w_pins;
         r_sync2 <= r_sync1;
         r_prev  <= r_flush[1] ? r_sync2 : 3'b000;
         if (!r_flush[1]) begin
            r_flush <= r_flush + 2'd1;
         end
      end
   end

   assign w_press = r_prev & ~r_sync2;

   logic w_add_ev;
   logic w_ded_ev;

`ifdef EDIT_AUTOREPEAT_EN
   localparam int c_rw = $clog2(REPEAT_DELAY + 1);
   localparam logic [c_rw-1:0] c_rep_fire   = c_rw'(REPEAT_DELAY);
   localparam logic [c_rw-1:0] c_rep_reload = c_rw'(REPEAT_DELAY - REPEAT_PERIOD + 1);

   logic [1:0] w_repeat;

   // Hold counter starts at 1 on the press; each time it hits the delay it is
   // pulled back so the next hit lands REPEAT_PERIOD cycles later.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rep
      logic [c_rw-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt <= '0;
         end else if (r_sync2[gi+1]) begin
            r_cnt <= '0;
         end else if (w_press[gi+1]) begin
            r_cnt <= c_rw'(1);
         end else if (r_cnt == c_rep_fire) begin
            r_cnt <= c_rep_reload;
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt + c_rw'(1);
         end
      end

      assign w_repeat[gi] = (r_cnt == c_rep_fire) && !r_sync2[gi+1];
   end

   assign w_add_ev = w_press[1] | w_repeat[0];
   assign w_ded_ev = w_press[2] | w_repeat[1];
`else
   // Repeat timing has no effect when auto-repeat is not built in.
   logic [31:0] w_unused_rep_cfg;
   assign w_unused_rep_cfg = REPEAT_DELAY ^ REPEAT_PERIOD;

   assign w_add_ev = w_press[1];
   assign w_ded_ev = w_press[2];
`endif

   logic                    w_sw_ev;
   logic                    w_any_ev;
   logic                    w_timeout;
   logic [c_fw-1:0]         w_field_nxt;
   logic [2*NUM_FIELDS-1:0] w_op_nxt;
   logic [c_iw-1:0]         r_idle;
   logic [c_iw-1:0]         w_idle_nxt;

   always_comb begin
      w_sw_ev     = w_press[0];
      w_any_ev    = w_sw_ev | w_add_ev | w_ded_ev;
      w_timeout   = (TIMEOUT_CYC != 0) && (field != '0) && !w_any_ev && (r_idle == c_idle_last);
      w_field_nxt = field;
      w_op_nxt    = '1;
      w_idle_nxt  = r_idle;

      // Switch outranks everything; simultaneous add+deduct cancel each other.
      if (w_sw_ev) begin
         w_field_nxt = (field == c_field_max) ? '0 : field + c_fw'(1);
      end else if (w_timeout) begin
         w_field_nxt = '0;
      end else if (w_add_ev != w_ded_ev) begin
         for (int i = 0; i < NUM_FIELDS; i++) begin
            if (field == c_fw'(i + 1)) begin
               w_op_nxt[2*i]   = ~w_add_ev;
               w_op_nxt[2*i+1] = ~w_ded_ev;
            end
         end
      end

      if (w_any_ev || (field == '0)) begin
         w_idle_nxt = '0;
      end else if (r_idle != c_idle_last) begin
         w_idle_nxt = r_idle + c_iw'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         field    <= '0;
         mode     <= 1'b0;
         operator <= '1;
         r_idle   <= '0;
      end else begin
         field    <= w_field_nxt;
         mode     <= (w_field_nxt != '0);
         operator <= w_op_nxt;
         r_idle   <= w_idle_nxt;
      end
   end

endmodule

`default_nettype wire
